// File: rtl/controller_pkg.sv
// Shared typedefs for the instruction-cycle controller: opcode and phase encodings.
package controller_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

endpackage

// File: rtl/controller.sv
// Eight-phase instruction-cycle sequencer; strobes are combinational decodes of
// the registered phase and the current opcode.
module controller
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic       data_e,
    output logic [2:0] phase
);

    localparam int unsigned PHASE_W = 3;

    phase_t state;
    phase_t state_next;
    logic   alu_op;

    // Phase register; reset forces INST_ADDR without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INST_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // Free-running phase counter, wraps STORE -> INST_ADDR.
    always_comb begin
        state_next = phase_t'(PHASE_W'(state) + PHASE_W'(1));
    end

    assign phase  = PHASE_W'(state);
    assign alu_op = (opcode == ADD) || (opcode == AND) ||
                    (opcode == XOR) || (opcode == LDA);

    // Strobe decode; INST_ADDR (and therefore reset) leaves every strobe low.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        case (state)
            INST_ADDR: begin
            end
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                mem_rd = alu_op;
            end
            ALU_OP: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
                data_e  = (opcode == STO);
            end
            STORE: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
                data_e  = (opcode == STO);
            end
            default: begin
            end
        endcase
    end

endmodule
